// File: rtl/cpu_io_fifo_port_pkg.sv
// Shared constants, status layout and wait-FSM state type for the CPU I/O FIFO port.
`default_nettype none

package cpu_io_fifo_port_pkg;

    localparam logic IOFP_DATA_OFS = 1'b0;
    localparam logic IOFP_STAT_OFS = 1'b1;

    localparam int IOFP_ST_RX_NE    = 0;
    localparam int IOFP_ST_TX_FULL  = 1;
    localparam int IOFP_ST_ERR      = 2;
    localparam int IOFP_ST_TX_EMPTY = 3;

    localparam int IOFP_CTL_FLUSH_TX = 0;
    localparam int IOFP_CTL_FLUSH_RX = 1;
    localparam int IOFP_CTL_CLR_ERR  = 7;

    localparam logic [7:0] IOFP_IDLE_DATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        HOLD       = 2'd2
    } iofp_state_t;

    function automatic logic [7:0] iofp_status(input logic tx_empty, input logic err,
                                               input logic tx_full, input logic rx_ne);
        logic [7:0] s;
        s                   = '0;
        s[IOFP_ST_RX_NE]    = rx_ne;
        s[IOFP_ST_TX_FULL]  = tx_full;
        s[IOFP_ST_ERR]      = err;
        s[IOFP_ST_TX_EMPTY] = tx_empty;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_io_fifo_port_sync_fifo.sv
// Single-clock byte FIFO with flush; pointers carry one extra wrap bit to tell full from empty.
`default_nettype none

module cpu_io_fifo_port_sync_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]        mem_q [DEPTH];
    logic                do_push;
    logic                do_pop;

    assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // Flush dominates; push against full and pop against empty are ignored.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/cpu_io_fifo_port.sv
// Z80 I/O responder: data/status port pair bridging the CPU to TX/RX byte FIFOs toward a host agent.
`default_nettype none

module cpu_io_fifo_port
    import cpu_io_fifo_port_pkg::*;
#(
    parameter logic [7:0] BASE_PORT    = 8'h40,
    parameter int         DEPTH_LOG2   = 4,
    parameter bit         WAIT_ON_FULL = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       cpu_iorq,
    input  logic       cpu_m1,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_data,
    output logic [7:0] data,
    output logic       data_oe_rq,
    output logic       cpu_wait,
    output logic [7:0] host_tx_data,
    output logic       host_tx_valid,
    input  logic       host_tx_ready,
    input  logic [7:0] host_rx_data,
    input  logic       host_rx_valid,
    output logic       host_rx_ready
);

    logic hit, sel_stat;
    logic rd_data_hit, rd_stat_hit, wr_data_hit, wr_ctl_hit;

    logic       tx_full, tx_empty, tx_push, tx_pop, tx_flush;
    logic [7:0] tx_push_data;
    logic       rx_full, rx_empty, rx_pop, rx_flush;
    logic [7:0] rx_head;

    iofp_state_t state_q, state_d;
    logic [7:0]  latch_q, latch_d;
    logic [7:0]  data_q, data_d;
    logic        oe_q, oe_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        tx_drop_q, tx_drop_d;
    logic        tx_drop_set;

    // Interrupt acknowledge (iorq & m1) never decodes as a port access.
    assign hit         = cpu_req & cpu_iorq & ~cpu_m1 & (cpu_addr[7:1] == BASE_PORT[7:1]);
    assign sel_stat    = (cpu_addr[0] == IOFP_STAT_OFS);
    assign rd_data_hit = hit & cpu_rd & ~sel_stat;
    assign rd_stat_hit = hit & cpu_rd & sel_stat;
    assign wr_data_hit = hit & cpu_wr & ~sel_stat;
    assign wr_ctl_hit  = hit & cpu_wr & sel_stat;

    assign tx_pop   = host_tx_ready & ~tx_empty;
    assign tx_flush = wr_ctl_hit & cpu_data[IOFP_CTL_FLUSH_TX];
    assign rx_pop   = rd_data_hit & ~rx_empty;
    assign rx_flush = wr_ctl_hit & cpu_data[IOFP_CTL_FLUSH_RX];

    cpu_io_fifo_port_sync_fifo #(
        .W          (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (tx_push),
        .push_data_i (tx_push_data),
        .pop_i       (tx_pop),
        .flush_i     (tx_flush),
        .head_o      (host_tx_data),
        .full_o      (tx_full),
        .empty_o     (tx_empty)
    );

    cpu_io_fifo_port_sync_fifo #(
        .W          (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (host_rx_valid),
        .push_data_i (host_rx_data),
        .pop_i       (rx_pop),
        .flush_i     (rx_flush),
        .head_o      (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty)
    );

    assign host_tx_valid = ~tx_empty;
    assign host_rx_ready = ~rx_full;

    // tx_full here is the pre-pop view, so a write racing a host pop still stalls one cycle.
    always_comb begin
        state_d      = state_q;
        latch_d      = latch_q;
        tx_push      = 1'b0;
        tx_push_data = cpu_data;
        tx_drop_set  = 1'b0;
        case (state_q)
            WAIT_SPACE: begin
                if (!tx_full) begin
                    tx_push      = 1'b1;
                    tx_push_data = latch_q;
                    state_d      = HOLD;
                end
            end
            default: begin
                if (wr_data_hit) begin
                    if (!tx_full) begin
                        tx_push = 1'b1;
                    end else if (WAIT_ON_FULL) begin
                        latch_d = cpu_data;
                        state_d = WAIT_SPACE;
                    end else begin
                        tx_drop_set = 1'b1;
                    end
                end else if (state_q == HOLD && !cpu_iorq) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign cpu_wait = (state_q == WAIT_SPACE);

    always_comb begin
        rx_overrun_d = rx_overrun_q;
        tx_drop_d    = tx_drop_q;
        if (wr_ctl_hit && cpu_data[IOFP_CTL_CLR_ERR]) begin
            rx_overrun_d = 1'b0;
            tx_drop_d    = 1'b0;
        end
        if (host_rx_valid && rx_full) rx_overrun_d = 1'b1;
        if (tx_drop_set)              tx_drop_d    = 1'b1;
    end

    // Read data is held for the rest of the I/O cycle, then returns to idle 8'hFF.
    always_comb begin
        data_d = data_q;
        oe_d   = oe_q;
        if (rd_data_hit) begin
            data_d = rx_empty ? IOFP_IDLE_DATA : rx_head;
            oe_d   = 1'b1;
        end else if (rd_stat_hit) begin
            data_d = iofp_status(tx_empty, rx_overrun_q | tx_drop_q, tx_full, ~rx_empty);
            oe_d   = 1'b1;
        end else if (oe_q && (!cpu_iorq || !cpu_rd)) begin
            data_d = IOFP_IDLE_DATA;
            oe_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            latch_q      <= '0;
            data_q       <= IOFP_IDLE_DATA;
            oe_q         <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            latch_q      <= latch_d;
            data_q       <= data_d;
            oe_q         <= oe_d;
            rx_overrun_q <= rx_overrun_d;
            tx_drop_q    <= tx_drop_d;
        end
    end

    assign data       = data_q;
    assign data_oe_rq = oe_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_io_fifo_port.sv
// Directed bench: a default instance (wait on full) and a drop-on-full instance share all inputs.
`default_nettype none

module tb_cpu_io_fifo_port;

    localparam int K_HPUSH = 0;
    localparam int K_IN    = 1;
    localparam int K_OUT   = 2;
    localparam int K_IACK  = 3;
    localparam int K_HPOP  = 4;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] exp;
        logic       exp_flag;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cpu_req, cpu_iorq, cpu_m1, cpu_rd, cpu_wr;
    logic [7:0] cpu_addr, cpu_data;
    logic       host_tx_ready, host_rx_valid;
    logic [7:0] host_rx_data;

    logic [7:0] data, host_tx_data;
    logic       data_oe_rq, cpu_wait, host_tx_valid, host_rx_ready;
    logic [7:0] data_nw, host_tx_data_nw;
    logic       data_oe_rq_nw, cpu_wait_nw, host_tx_valid_nw, host_rx_ready_nw;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cpu_io_fifo_port dut (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_iorq(cpu_iorq), .cpu_m1(cpu_m1),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .data(data), .data_oe_rq(data_oe_rq), .cpu_wait(cpu_wait),
        .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready)
    );

    cpu_io_fifo_port #(.WAIT_ON_FULL(1'b0)) dut_nw (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_iorq(cpu_iorq), .cpu_m1(cpu_m1),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .data(data_nw), .data_oe_rq(data_oe_rq_nw), .cpu_wait(cpu_wait_nw),
        .host_tx_data(host_tx_data_nw), .host_tx_valid(host_tx_valid_nw), .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready_nw)
    );

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int k, input logic [7:0] a, input logic [7:0] w,
                       input logic [7:0] e, input logic f);
        vecs.push_back('{k, a, w, e, f});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_iorq = 1'b0; cpu_m1 = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cpu_addr = 8'h00; cpu_data = 8'h00;
        host_tx_ready = 1'b0; host_rx_valid = 1'b0; host_rx_data = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One complete I/O cycle; read data is sampled the cycle after the request strobe.
    task automatic cpu_io(input logic is_rd, input logic m1, input logic [7:0] a, input logic [7:0] wd,
                          output logic [7:0] rd_d, output logic rd_oe, output logic [7:0] rd_d_nw);
        @(negedge clk);
        cpu_req = 1'b1; cpu_iorq = 1'b1; cpu_m1 = m1; cpu_rd = is_rd; cpu_wr = ~is_rd;
        cpu_addr = a; cpu_data = wd;
        @(negedge clk);
        cpu_req = 1'b0;
        rd_d = data; rd_oe = data_oe_rq; rd_d_nw = data_nw;
        @(negedge clk);
        cpu_iorq = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_m1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic host_push(input logic [7:0] d, output logic rdy);
        @(negedge clk);
        host_rx_valid = 1'b1; host_rx_data = d; rdy = host_rx_ready;
        @(negedge clk);
        host_rx_valid = 1'b0;
    endtask

    task automatic host_pop(output logic [7:0] d, output logic v,
                            output logic [7:0] d_nw, output logic v_nw);
        @(negedge clk);
        host_tx_ready = 1'b1;
        d = host_tx_data; v = host_tx_valid; d_nw = host_tx_data_nw; v_nw = host_tx_valid_nw;
        @(negedge clk);
        host_tx_ready = 1'b0;
    endtask

    task automatic fill_tx();
        logic [7:0] d, dn;
        logic       o;
        for (int i = 0; i < 16; i++) cpu_io(1'b0, 1'b0, 8'h40, 8'(i), d, o, dn);
    endtask

    initial begin
        logic [7:0] d, dn;
        logic       o, v, vn;

        add(K_HPUSH, 8'h00, 8'hA5, 8'h00, 1'b1);
        add(K_HPUSH, 8'h00, 8'h3C, 8'h00, 1'b1);
        add(K_IN,    8'h41, 8'h00, 8'h09, 1'b1);
        add(K_IN,    8'h40, 8'h00, 8'hA5, 1'b1);
        add(K_IN,    8'h41, 8'h00, 8'h09, 1'b1);
        add(K_IN,    8'h40, 8'h00, 8'h3C, 1'b1);
        add(K_IN,    8'h41, 8'h00, 8'h08, 1'b1);
        add(K_IN,    8'h40, 8'h00, 8'hFF, 1'b1);
        add(K_IN,    8'h41, 8'h00, 8'h08, 1'b1);
        add(K_IN,    8'h42, 8'h00, 8'hFF, 1'b0);
        add(K_HPUSH, 8'h00, 8'h77, 8'h00, 1'b1);
        add(K_IACK,  8'h40, 8'h00, 8'hFF, 1'b0);
        add(K_IN,    8'h41, 8'h00, 8'h09, 1'b1);
        add(K_IN,    8'h40, 8'h00, 8'h77, 1'b1);
        add(K_HPUSH, 8'h00, 8'h11, 8'h00, 1'b1);
        add(K_OUT,   8'h41, 8'h02, 8'h00, 1'b0);
        add(K_IN,    8'h41, 8'h00, 8'h08, 1'b1);
        add(K_OUT,   8'h40, 8'h5A, 8'h00, 1'b0);
        add(K_IN,    8'h41, 8'h00, 8'h00, 1'b1);
        add(K_HPOP,  8'h00, 8'h00, 8'h5A, 1'b1);
        add(K_IN,    8'h41, 8'h00, 8'h08, 1'b1);
        add(K_OUT,   8'h40, 8'h12, 8'h00, 1'b0);
        add(K_OUT,   8'h41, 8'h01, 8'h00, 1'b0);
        add(K_IN,    8'h41, 8'h00, 8'h08, 1'b1);
        add(K_HPOP,  8'h00, 8'h00, 8'h00, 1'b0);

        do_reset();
        reset_n = 1'b0;
        #1;
        check("reset data", {1'b0, data}, 9'h0FF);
        check("reset data_oe_rq", {8'h00, data_oe_rq}, 9'h000);
        check("reset cpu_wait", {8'h00, cpu_wait}, 9'h000);
        check("reset host_tx_valid", {8'h00, host_tx_valid}, 9'h000);
        check("reset host_rx_ready", {8'h00, host_rx_ready}, 9'h001);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            case (vecs[i].kind)
                K_HPUSH: begin
                    host_push(vecs[i].wd, o);
                    check($sformatf("vec%0d rx_ready", i), {8'h00, o}, {8'h00, vecs[i].exp_flag});
                end
                K_HPOP: begin
                    host_pop(d, v, dn, vn);
                    check($sformatf("vec%0d tx_valid", i), {8'h00, v}, {8'h00, vecs[i].exp_flag});
                    if (vecs[i].exp_flag)
                        check($sformatf("vec%0d tx_data", i), {1'b0, d}, {1'b0, vecs[i].exp});
                end
                K_OUT: cpu_io(1'b0, 1'b0, vecs[i].addr, vecs[i].wd, d, o, dn);
                default: begin
                    cpu_io(1'b1, vecs[i].kind == K_IACK, vecs[i].addr, 8'h00, d, o, dn);
                    check($sformatf("vec%0d data", i), {1'b0, d}, {1'b0, vecs[i].exp});
                    check($sformatf("vec%0d oe", i), {8'h00, o}, {8'h00, vecs[i].exp_flag});
                    check($sformatf("vec%0d release", i), {data_oe_rq, data}, 9'h0FF);
                end
            endcase
        end

        // TX full: wait-state instance stalls, drop instance discards and flags.
        do_reset();
        fill_tx();
        check("full tx_valid", {8'h00, host_tx_valid}, 9'h001);
        cpu_io(1'b1, 1'b0, 8'h41, 8'h00, d, o, dn);
        check("full status", {1'b0, d}, 9'h002);
        @(negedge clk);
        cpu_req = 1'b1; cpu_iorq = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h40; cpu_data = 8'h55;
        @(negedge clk);
        cpu_req = 1'b0;
        check("wait asserted", {8'h00, cpu_wait}, 9'h001);
        check("nowait no stall", {8'h00, cpu_wait_nw}, 9'h000);
        repeat (3) @(negedge clk);
        check("wait held", {8'h00, cpu_wait}, 9'h001);
        host_tx_ready = 1'b1;
        check("pop head", {1'b0, host_tx_data}, 9'h000);
        @(negedge clk);
        host_tx_ready = 1'b0;
        check("wait pop clk", {8'h00, cpu_wait}, 9'h001);
        @(negedge clk);
        check("wait released", {8'h00, cpu_wait}, 9'h000);
        cpu_iorq = 1'b0; cpu_wr = 1'b0;
        @(negedge clk);
        cpu_io(1'b1, 1'b0, 8'h41, 8'h00, d, o, dn);
        check("refill status", {1'b0, d}, 9'h002);
        check("drop status", {1'b0, dn}, 9'h004);
        cpu_io(1'b0, 1'b0, 8'h41, 8'h80, d, o, dn);
        cpu_io(1'b1, 1'b0, 8'h41, 8'h00, d, o, dn);
        check("drop cleared", {1'b0, dn}, 9'h000);
        for (int i = 0; i < 16; i++) begin
            host_pop(d, v, dn, vn);
            check($sformatf("drain%0d", i), {v, d}, {1'b1, (i < 15) ? 8'(i + 1) : 8'h55});
            check($sformatf("drain_nw%0d", i), {vn, (i < 15) ? dn : 8'h00},
                  {(i < 15), (i < 15) ? 8'(i + 1) : 8'h00});
        end
        check("drained", {8'h00, host_tx_valid}, 9'h000);

        // RX full: host refused and overrun flagged; CPU pop frees a slot for the next clk.
        do_reset();
        for (int i = 0; i < 16; i++) host_push(8'(8'h80 + i), o);
        check("rx full ready", {8'h00, host_rx_ready}, 9'h000);
        @(negedge clk);
        host_rx_valid = 1'b1; host_rx_data = 8'hEE;
        cpu_req = 1'b1; cpu_iorq = 1'b1; cpu_rd = 1'b1; cpu_addr = 8'h40;
        check("overrun ready", {8'h00, host_rx_ready}, 9'h000);
        @(negedge clk);
        cpu_req = 1'b0;
        check("overrun pop data", {1'b0, data}, 9'h080);
        check("slot freed", {8'h00, host_rx_ready}, 9'h001);
        @(negedge clk);
        host_rx_valid = 1'b0;
        check("slot refilled", {8'h00, host_rx_ready}, 9'h000);
        cpu_iorq = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
        cpu_io(1'b1, 1'b0, 8'h41, 8'h00, d, o, dn);
        check("overrun status", {1'b0, d}, 9'h00D);
        for (int i = 1; i < 17; i++) begin
            cpu_io(1'b1, 1'b0, 8'h40, 8'h00, d, o, dn);
            check($sformatf("rx read%0d", i), {1'b0, d}, {1'b0, (i < 16) ? 8'(8'h80 + i) : 8'hEE});
        end
        cpu_io(1'b1, 1'b0, 8'h41, 8'h00, d, o, dn);
        check("rx empty status", {1'b0, d}, 9'h00C);
        cpu_io(1'b0, 1'b0, 8'h41, 8'h80, d, o, dn);
        cpu_io(1'b1, 1'b0, 8'h41, 8'h00, d, o, dn);
        check("overrun cleared", {1'b0, d}, 9'h008);

        // Reset while stalled: wait drops asynchronously and the latched byte is gone.
        do_reset();
        fill_tx();
        @(negedge clk);
        cpu_req = 1'b1; cpu_iorq = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h40; cpu_data = 8'h55;
        @(negedge clk);
        cpu_req = 1'b0;
        check("pre-reset wait", {8'h00, cpu_wait}, 9'h001);
        #2 reset_n = 1'b0;
        #1;
        check("async wait drop", {8'h00, cpu_wait}, 9'h000);
        check("async tx empty", {8'h00, host_tx_valid}, 9'h000);
        @(negedge clk);
        reset_n = 1'b1; cpu_iorq = 1'b0; cpu_wr = 1'b0;
        host_push(8'h21, o);
        cpu_io(1'b1, 1'b0, 8'h41, 8'h00, d, o, dn);
        check("post-reset status", {1'b0, d}, 9'h009);
        check("latched byte lost", {8'h00, host_tx_valid}, 9'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
